// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller.
//   - state_t   : controller FSM states
//   - DEF_WIDTH : default operand / datapath register width
//   - DEF_CNT_W : default shift-counter width (must be able to hold DEF_WIDTH)
//   - OP_ADD / OP_SUB : encodings of the addsub strobe
package booth_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    LDM,
    LDQ,
    CHECK,
    ARITH,
    SHIFT,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/booth_controller_if.sv
// Host-side handshake bundle for the Booth controller.
//   start_valid / start_ready : operand pair offer / accept
//   mcand / mplier            : operands, captured on accept
//   result_valid / result_ready : product (or watchdog error) complete / acknowledge
//   err                       : sticky watchdog error
// Modports:
//   master : the requester that supplies operands and consumes results
//   slave  : the controller
interface booth_controller_if
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             result_valid;
  logic             result_ready;
  logic             err;

  modport master (
    output start_valid,
    output mcand,
    output mplier,
    output result_ready,
    input  start_ready,
    input  result_valid,
    input  err
  );

  modport slave (
    input  start_valid,
    input  mcand,
    input  mplier,
    input  result_ready,
    output start_ready,
    output result_valid,
    output err
  );

endinterface

// File: rtl/booth_controller.sv
// Sequencing FSM for a radix-2 Booth multiplier datapath.
// Accepts an operand pair over host (valid/ready), reinitialises the datapath,
// loads M then Q over the shared dp_data bus, then for every bit issues an
// optional add/sub (ldA/addsub) followed by an arithmetic shift, and holds
// result_valid until result_ready. A watchdog moves to ERR if the datapath's
// zero status never asserts after WIDTH shifts.
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-low reset
//   host           : handshake bundle (slave modport)
//   dp_clr         : datapath reinitialise strobe
//   dp_data        : datapath data_in bus (mcand in LDM, mplier in LDQ, else 0)
//   ldM, ldQ       : load M / Q from dp_data
//   ldA, addsub    : A update enable, 1 = A+M, 0 = A-M
//   shift          : arithmetic right shift of {A,Q,Qm1}
//   Q0, Qm1, zero  : datapath status inputs
module booth_controller
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  booth_controller_if.slave host,
  output logic             dp_clr,
  output logic [WIDTH-1:0] dp_data,
  output logic             ldM,
  output logic             ldQ,
  output logic             ldA,
  output logic             addsub,
  output logic             shift,
  input  logic             Q0,
  input  logic             Qm1,
  input  logic             zero
);

  state_t             state_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               err_reg;
  logic               start_ready_reg;
  logic               result_valid_reg;
  logic               dp_clr_reg;
  logic [WIDTH-1:0]   dp_data_reg;
  logic               ld_m_reg;
  logic               ld_q_reg;
  logic               ld_a_reg;
  logic               addsub_reg;
  logic               shift_reg;

  // Outputs are registered alongside the state: each transition below raises
  // exactly the strobes that belong to the state being entered, so every
  // output is a pure function of the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      mcand_reg        <= '0;
      mplier_reg       <= '0;
      cnt_reg          <= '0;
      err_reg          <= 1'b0;
      start_ready_reg  <= 1'b1;
      result_valid_reg <= 1'b0;
      dp_clr_reg       <= 1'b0;
      dp_data_reg      <= '0;
      ld_m_reg         <= 1'b0;
      ld_q_reg         <= 1'b0;
      ld_a_reg         <= 1'b0;
      addsub_reg       <= 1'b0;
      shift_reg        <= 1'b0;
    end else begin
      start_ready_reg  <= 1'b0;
      result_valid_reg <= 1'b0;
      dp_clr_reg       <= 1'b0;
      dp_data_reg      <= '0;
      ld_m_reg         <= 1'b0;
      ld_q_reg         <= 1'b0;
      ld_a_reg         <= 1'b0;
      addsub_reg       <= 1'b0;
      shift_reg        <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (host.start_valid) begin
            mcand_reg  <= host.mcand;
            mplier_reg <= host.mplier;
            err_reg    <= 1'b0;
            state_reg  <= CLR;
            dp_clr_reg <= 1'b1;
          end else begin
            start_ready_reg <= 1'b1;
          end
        end

        CLR: begin
          cnt_reg     <= '0;
          state_reg   <= LDM;
          ld_m_reg    <= 1'b1;
          dp_data_reg <= mcand_reg;
        end

        LDM: begin
          state_reg   <= LDQ;
          ld_q_reg    <= 1'b1;
          dp_data_reg <= mplier_reg;
        end

        LDQ: begin
          state_reg <= CHECK;
        end

        // zero has priority over the watchdog so a healthy datapath that
        // finishes exactly on the WIDTH-th shift completes normally.
        CHECK: begin
          if (zero) begin
            state_reg        <= DONE;
            result_valid_reg <= 1'b1;
          end else if (cnt_reg == CNT_W'(WIDTH)) begin
            state_reg        <= ERR;
            result_valid_reg <= 1'b1;
            err_reg          <= 1'b1;
          end else if ({Q0, Qm1} == 2'b10) begin
            state_reg  <= ARITH;
            ld_a_reg   <= 1'b1;
            addsub_reg <= OP_SUB;
          end else if ({Q0, Qm1} == 2'b01) begin
            state_reg  <= ARITH;
            ld_a_reg   <= 1'b1;
            addsub_reg <= OP_ADD;
          end else begin
            state_reg <= SHIFT;
            shift_reg <= 1'b1;
          end
        end

        ARITH: begin
          state_reg <= SHIFT;
          shift_reg <= 1'b1;
        end

        SHIFT: begin
          cnt_reg   <= cnt_reg + 1'b1;
          state_reg <= CHECK;
        end

        DONE, ERR: begin
          if (host.result_ready) begin
            state_reg       <= IDLE;
            start_ready_reg <= 1'b1;
          end else begin
            result_valid_reg <= 1'b1;
          end
        end

        default: begin
          state_reg       <= IDLE;
          start_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign host.start_ready  = start_ready_reg;
  assign host.result_valid = result_valid_reg;
  assign host.err          = err_reg;
  assign dp_clr            = dp_clr_reg;
  assign dp_data           = dp_data_reg;
  assign ldM               = ld_m_reg;
  assign ldQ               = ld_q_reg;
  assign ldA               = ld_a_reg;
  assign addsub            = addsub_reg;
  assign shift             = shift_reg;

endmodule

// File: doc/booth_controller.md
Name: booth_controller

Overview:
Sequencing FSM for the radix-2 Booth multiplier datapath (16-bit A/Q/M registers, shared data_in bus, Q0/Qm1/zero status).
- Accepts an operand pair over a valid/ready handshake and reinitialises the datapath.
- Loads M, then Q, over the single shared bus.
- Issues add/sub and shift strobes per Booth pair, and holds a done indication until acknowledged.
- A watchdog flags a datapath whose `zero` status never asserts.

Parameters:
- WIDTH, 16, operand width; equals datapath register width and shift count.
- CNT_W, 5, width of internal shift counter; must hold the value WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start_valid  in  1  operand pair offered.
- start_ready  out  1  controller can accept (high only in IDLE).
- mcand  in  WIDTH  multiplicand, captured on accept.
- mplier  in  WIDTH  multiplier, captured on accept.
- result_valid  out  1  product complete in datapath {A,Q}.
- result_ready  in  1  consumer acknowledge.
- err  out  1  sticky watchdog error; cleared only by reset or the next accept.
- dp_clr  out  1  datapath reinitialise strobe (clears A/Q/M/Qm1, count=WIDTH).
- dp_data  out  WIDTH  drives datapath data_in.
- ldM  out  1  load M from dp_data.
- ldQ  out  1  load Q from dp_data.
- ldA  out  1  A update enable.
- addsub  out  1  1=A+M, 0=A-M; meaningful only with ldA.
- shift  out  1  arithmetic right shift of {A,Q,Qm1}, count decrement.
- Q0  in  1  datapath Q[0].
- Qm1  in  1  datapath Q[-1].
- zero  in  1  datapath count==0.

Behaviour:
- Moore FSM. All strobes decode from the state register only, never combinationally from inputs; one strobe state per cycle.
- Reset (rst low, any time including mid-operation):
  - State = IDLE; captured operands = 0; shift counter = 0; err = 0.
  - All outputs 0 except start_ready = 1.
  - No partial strobe is emitted on reset release.
- States and transitions:
  - IDLE: start_ready=1. On start_valid: capture mcand/mplier, clear err, go to CLR.
  - CLR: dp_clr=1, shift counter=0. Go to LDM.
  - LDM: ldM=1, dp_data=mcand. Go to LDQ.
  - LDQ: ldQ=1, dp_data=mplier. Go to CHECK.
  - CHECK: no strobes.
    - If zero=1: go to DONE.
    - Else if shift counter==WIDTH: go to ERR (watchdog).
    - Else if {Q0,Qm1}==2'b10: go to ARITH with addsub=0 (subtract).
    - Else if {Q0,Qm1}==2'b01: go to ARITH with addsub=1 (add).
    - Else (00 or 11): go to SHIFT.
  - ARITH: ldA=1, addsub as latched from CHECK. Go to SHIFT.
  - SHIFT: shift=1, shift counter+1. Go to CHECK.
  - DONE: result_valid=1. On result_ready: go to IDLE. result_valid may not drop until result_ready is sampled high.
  - ERR: err=1, result_valid=1. On result_ready: go to IDLE.
- ldA and shift are never asserted in the same cycle, because the datapath gives shift priority over A update.
- dp_data is 0 outside LDM/LDQ.
- Latency from the accept edge to DONE entry = 3 + 2*WIDTH + k + 1 cycles, where k = number of ARITH visits (0..WIDTH). For WIDTH=16 the range is 36..52.
- start_valid outside IDLE is ignored; operands are not recaptured.
- result_ready outside DONE/ERR is ignored.
- Back-to-back operation: start_valid held high gives IDLE→CLR the cycle after DONE exits.

Decomposition:
- booth_pkg holds:
  - State enum: IDLE, CLR, LDM, LDQ, CHECK, ARITH, SHIFT, DONE, ERR.
  - WIDTH default.
  - Constants OP_ADD=1'b1, OP_SUB=1'b0.
- No sub-module inside the controller.
- booth_top instantiates booth_controller plus the datapath. It inverts rst for the datapath's active-high reset and ORs in dp_clr.

Test Plan:
- mcand=3, mplier=5, result_ready=1 → ldA pulses 4 times (sub, add, sub, add); DONE entered 40 cycles after accept; {A,Q}=0x0000000F.
- mcand=0x0007, mplier=0x0000 → no ldA; DONE at 36 cycles; product 0.
- mcand=0xFFFC (-4), mplier=0x5555 → k=16, DONE at 52 cycles; product 0xFFFEAAAC; shift pulses exactly 16.
- mplier=0xFFFF (-1), mcand=9 → single subtract, DONE at 37 cycles; product 0xFFFFFFF7. Hold result_ready=0 for 10 cycles → result_valid stays 1 and start_ready stays 0.
- rst asserted during SHIFT of a multiply → all strobes 0 immediately, start_ready=1. A new 3*5 afterwards yields 15 and 40-cycle latency.
- zero tied 0 → ERR after 16 SHIFTs, err=1, result_valid=1. result_ready returns to IDLE with err sticky; next accept clears err.
